sync_ram_stream_reader: RTL
===========================

Name: sync_ram_stream_reader

Overview:
Read-side engine for the single-port-RAM FIFO family. It accepts a command (start address, word count) and issues reads to a single-port RAM with fixed 2-cycle read latency. Returned words are buffered in a small prefetch register FIFO and streamed out on a valid/ready port with a last marker. Credit-based issue guarantees no returned word is ever dropped under output back-pressure.

Parameters:
DATA_WIDTH, 8, RAM word and output data width
RAM_DEPTH, 256, RAM words; addresses wrap modulo RAM_DEPTH; power of two
PREFETCH_DEPTH, 4, prefetch FIFO entries; also max words in flight plus buffered
LB_RAM_DEPTH, $clog2(RAM_DEPTH), localparam, address width
LB_PREFETCH_DEPTH, $clog2(PREFETCH_DEPTH), localparam

Ports:
clk  in  1  clock
rstn  in  1  reset, asynchronous, active-low
cmd_addr  in  LB_RAM_DEPTH  start address
cmd_len  in  LB_RAM_DEPTH+1  word count, 0..RAM_DEPTH
cmd_valid  in  1  command valid
cmd_ready  out  1  high only in IDLE
ram_addr  out  LB_RAM_DEPTH  RAM address, combinational
ram_rd_en  out  1  read issue strobe, combinational
ram_dout  in  DATA_WIDTH  RAM read data, valid 2 cycles after the issue cycle
out_data  out  DATA_WIDTH  stream data
out_last  out  1  marks the final word of a command
out_valid  out  1  stream valid
out_ready  in  1  stream ready
abort  in  1  synchronous flush of the current command
busy  out  1  state != IDLE
remaining  out  LB_RAM_DEPTH+1  words of the current command not yet handshaken on out

Behaviour:
- Reset: state IDLE; all counters, address registers and the latency pipe are 0. Outputs: cmd_ready=1, busy=0, out_valid=0, out_last=0, ram_rd_en=0, remaining=0, ram_addr=0.
- FSM states: IDLE, RUN, DRAIN.
- IDLE: cmd_valid&cmd_ready loads rd_addr=cmd_addr, issue_left=cmd_len and remaining=cmd_len.
  - cmd_len=0: stays IDLE; no reads, no output.
  - Otherwise: RUN.
- RUN: ram_rd_en=1 when issue_left>0 and (prefetch_count + inflight) < PREFETCH_DEPTH. inflight = number of set bits in the 2-stage valid pipe.
  - On issue: ram_addr=rd_addr; rd_addr+1 wraps RAM_DEPTH-1→0; issue_left-1.
  - Each issue pushes {valid=1, last=(issue_left==1)} into the pipe.
  - When the last read issues: RUN→DRAIN.
- Latency pipe: stage[0] loads on issue, stage[1]<=stage[0]. When stage[1] is valid, {last, ram_dout} is pushed into the prefetch FIFO in that cycle.
  - The credit rule guarantees the FIFO is never full at push time. An assertion checks this.
- Output: out_valid/out_data/out_last come from the prefetch FIFO head. remaining decrements on each out_valid&out_ready.
- DRAIN: stays until the handshake of the word with out_last=1, then IDLE. cmd_ready is asserted the following cycle.
- Timing: command accepted at cycle 0, first ram_rd_en at cycle 1, FIFO push at cycle 3, first out_valid at cycle 4.
- Throughput: 1 word/cycle with out_ready held high and PREFETCH_DEPTH≥4.
- Back-pressure: with out_ready=0, at most PREFETCH_DEPTH reads are outstanding plus buffered, then issue stalls. Issue resumes the cycle after a handshake frees a credit.
- abort (any state): next cycle state=IDLE; pipe, issue_left and remaining cleared; prefetch FIFO cleared via clear.
  - out_valid=0 from the next cycle. Returned data from already-issued reads is discarded.
  - abort has priority over a same-cycle cmd handshake; that command is not accepted.
- Simultaneous push to and pop from the prefetch FIFO in the same cycle is legal; count is unchanged.
- Reset asserted mid-command: immediate return to reset values; in-flight RAM data is ignored.
- cmd_len=RAM_DEPTH reads the whole RAM once, starting at cmd_addr, with wrap.

Decomposition:
- Package sync_ram_reader_pkg: state_t enum (IDLE, RUN, DRAIN) and the RAM_READ_LATENCY=2 constant.
- Sub-module: the existing reg_fifo, instantiated with width DATA_WIDTH+1 ({last, data}) and depth PREFETCH_DEPTH. Its clear is driven by abort.
- The latency pipe, credit logic and FSM live in the top module.

Test Plan:
1. cmd_addr=0x10, cmd_len=4, out_ready=1, RAM[i]=i → out_data 0x10,0x11,0x12,0x13 on cycles 4-7, out_last on 0x13, cmd_ready high again on cycle 8.
2. cmd_addr=0xFE, cmd_len=4 → ram_addr sequence FE,FF,00,01; outputs match RAM contents in that order.
3. cmd_len=16, out_ready=0 for 20 cycles → exactly 4 ram_rd_en pulses, out_valid held with data RAM[addr]; release → remaining 16 words in order, no loss or duplication.
4. cmd_len=0 → no ram_rd_en, no out_valid, cmd_ready stays 1, busy stays 0.
5. cmd_len=8, abort at cycle 5 → out_valid=0 and busy=0 from cycle 6; next cmd_addr=0x40, cmd_len=2 produces only RAM[0x40], RAM[0x41].
6. Random out_ready at 50% over 200 commands with random addr/len → scoreboard exact order, one out_last per command, remaining hits 0 at each last word.

Source files
------------

// File: rtl/sync_ram_reader_pkg.sv
// Shared types and constants for the single-port-RAM stream reader.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sync_ram_reader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Cycles from a read issue until ram_dout carries that word.
  localparam int RAM_READ_LATENCY = 2;

endpackage

// File: rtl/reg_fifo.sv
// Small register-based FIFO with synchronous clear; head visible on pop_data.
// Latency: a pushed word is visible at the head the cycle after the push.
// Backpressure: push ignored while full, pop ignored while empty; push+pop same cycle keeps count.
//
// Ports: clk, rstn (async active-low), clear (sync flush, wins over push/pop),
//        push/push_data/full, pop/pop_data/empty, count (entries held).
module reg_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage needs no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/sync_ram_stream_reader.sv
// Reads cmd_len words from a 2-cycle-latency single-port RAM and streams them out with a last marker.
// Latency: command accepted cycle 0, first read cycle 1, first out_valid cycle 4; 1 word/cycle sustained.
// Backpressure: reads are issued only while buffered+in-flight words < PREFETCH_DEPTH, so nothing is dropped.
//
// Ports: cmd_addr/cmd_len/cmd_valid/cmd_ready  command in (ready only in IDLE)
//        ram_addr/ram_rd_en/ram_dout           RAM read port (addr/en combinational)
//        out_data/out_last/out_valid/out_ready stream out
//        abort (sync flush), busy (not IDLE), remaining (words not yet handshaken)
module sync_ram_stream_reader
  import sync_ram_reader_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int RAM_DEPTH      = 256,
  parameter int PREFETCH_DEPTH = 4,
  localparam int LB_RAM_DEPTH      = $clog2(RAM_DEPTH),
  localparam int LB_PREFETCH_DEPTH = $clog2(PREFETCH_DEPTH)
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [LB_RAM_DEPTH-1:0] cmd_addr,
  input  logic [LB_RAM_DEPTH:0]   cmd_len,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  output logic [LB_RAM_DEPTH-1:0] ram_addr,
  output logic                    ram_rd_en,
  input  logic [DATA_WIDTH-1:0]   ram_dout,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic                    out_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  input  logic                    abort,
  output logic                    busy,
  output logic [LB_RAM_DEPTH:0]   remaining
);

  localparam int LAT = RAM_READ_LATENCY;
  localparam int LW  = LB_RAM_DEPTH + 1;
  localparam int IFW = $clog2(LAT + 1);
  localparam int CRW = $clog2(PREFETCH_DEPTH + LAT + 1);

  state_t                    state;
  state_t                    state_nxt;
  logic [LB_RAM_DEPTH-1:0]   rd_addr;
  logic [LW-1:0]             issue_left;
  logic [LAT-1:0]            pipe_vld;
  logic [LAT-1:0]            pipe_last;
  logic [IFW-1:0]            inflight;
  logic [CRW-1:0]            credit_used;
  logic [LB_PREFETCH_DEPTH:0] fifo_count;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic                      cmd_accept;
  logic                      out_hs;

  assign ram_addr   = rd_addr;
  assign out_valid  = !fifo_empty;
  assign out_hs     = out_valid && out_ready;
  assign cmd_accept = cmd_valid && cmd_ready && !abort;

  // Words issued but not yet popped: those still in the read pipe plus those buffered.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < LAT; i++) inflight = inflight + IFW'(pipe_vld[i]);
  end
  assign credit_used = CRW'(fifo_count) + CRW'(inflight);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    busy      = 1'b1;
    ram_rd_en = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_accept && cmd_len != '0) state_nxt = RUN;
      end
      RUN: begin
        ram_rd_en = (issue_left != '0) && (credit_used < CRW'(PREFETCH_DEPTH));
        if (ram_rd_en && issue_left == LW'(1)) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (out_hs && out_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (abort) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_addr    <= '0;
      issue_left <= '0;
      remaining  <= '0;
      pipe_vld   <= '0;
      pipe_last  <= '0;
    end else if (abort) begin
      // Reads already issued still return on ram_dout; dropping the pipe discards them.
      issue_left <= '0;
      remaining  <= '0;
      pipe_vld   <= '0;
      pipe_last  <= '0;
    end else begin
      pipe_vld  <= {pipe_vld[LAT-2:0], ram_rd_en};
      pipe_last <= {pipe_last[LAT-2:0], ram_rd_en && (issue_left == LW'(1))};
      if (cmd_accept) begin
        rd_addr    <= cmd_addr;
        issue_left <= cmd_len;
      end else if (ram_rd_en) begin
        rd_addr    <= rd_addr + LB_RAM_DEPTH'(1);
        issue_left <= issue_left - LW'(1);
      end
      if (cmd_accept)  remaining <= cmd_len;
      else if (out_hs) remaining <= remaining - LW'(1);
    end
  end

  reg_fifo #(
    .WIDTH (DATA_WIDTH + 1),
    .DEPTH (PREFETCH_DEPTH)
  ) u_prefetch (
    .clk       (clk),
    .rstn      (rstn),
    .clear     (abort),
    .push      (pipe_vld[LAT-1]),
    .push_data ({pipe_last[LAT-1], ram_dout}),
    .full      (fifo_full),
    .pop       (out_ready),
    .pop_data  ({out_last, out_data}),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  a_no_push_when_full: assert property (@(posedge clk) disable iff (!rstn)
    pipe_vld[LAT-1] |-> !fifo_full);

endmodule
